// File: rtl/ws2812_receiver.sv
// WS2812 one-wire receiver: pulse-width decode of din into 24-bit GRB pixels with frame tracking.
// Latency: pixel_valid is high in the cycle after the 3rd clk edge that samples the last bit's falling din.
// No backpressure: strobes are single-cycle and pixel_data holds until the next pixel completes.
module ws2812_receiver #(
  parameter int BIT_THRESHOLD = 30,
  parameter int MAX_HIGH      = 100,
  parameter int RESET_CYCLES  = 2500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  output logic [23:0] pixel_data,
  output logic        pixel_valid,
  output logic [15:0] pixel_index,
  output logic        frame_done,
  output logic [15:0] frame_pixels,
  output logic        bit_error,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, ERR} state_t;

  // Counters hold "cycles since the edge minus one", so thresholds are offset by one.
  localparam logic [15:0] HI_ONE = 16'(BIT_THRESHOLD - 1);
  localparam logic [15:0] HI_ERR = 16'(MAX_HIGH - 1);
  localparam logic [15:0] LO_END = 16'(RESET_CYCLES - 1);

  state_t      state, state_next;
  logic        din_s1, din_s2, din_s3;
  logic        rise, fall;
  logic [15:0] hcnt, lcnt, pcnt;
  logic [23:0] shreg;
  logic [4:0]  bitcnt;
  logic        do_bit, do_err, do_end, bit_val;

  assign rise    = din_s2 & ~din_s3;
  assign fall    = ~din_s2 & din_s3;
  assign bit_val = (hcnt >= HI_ONE);

  // Two-flop synchronizer plus one history flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_s1 <= 1'b0;
      din_s2 <= 1'b0;
      din_s3 <= 1'b0;
    end else begin
      din_s1 <= din;
      din_s2 <= din_s1;
      din_s3 <= din_s2;
    end
  end

  // Line state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode and the one-cycle decode events driving the datapath.
  always_comb begin
    state_next = state;
    do_bit     = 1'b0;
    do_err     = 1'b0;
    do_end     = 1'b0;
    case (state)
      IDLE: if (rise) state_next = HIGH;
      HIGH: begin
        if (fall) begin
          state_next = LOW;
          do_bit     = 1'b1;
        end else if (hcnt >= HI_ERR) begin
          state_next = ERR;
          do_err     = 1'b1;
        end
      end
      LOW: begin
        if (rise) begin
          state_next = HIGH;
        end else if (lcnt >= LO_END) begin
          state_next = IDLE;
          do_end     = 1'b1;
        end
      end
      ERR: if (fall) state_next = LOW;
      default: state_next = IDLE;
    endcase
  end

  // Pulse counters, bit assembly, pixel/frame bookkeeping and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt         <= '0;
      lcnt         <= '0;
      pcnt         <= '0;
      shreg        <= '0;
      bitcnt       <= '0;
      pixel_data   <= '0;
      pixel_valid  <= 1'b0;
      pixel_index  <= '0;
      frame_done   <= 1'b0;
      frame_pixels <= '0;
      bit_error    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      bit_error   <= 1'b0;

      if (rise)                               hcnt <= '0;
      else if (state == HIGH && hcnt != 16'hFFFF) hcnt <= hcnt + 16'd1;

      if (fall)                                                  lcnt <= '0;
      else if ((state == LOW || state == ERR) && lcnt != 16'hFFFF) lcnt <= lcnt + 16'd1;

      if (state == IDLE && rise) busy <= 1'b1;

      if (do_bit) begin
        if (bitcnt == 5'd23) begin
          pixel_data  <= {shreg[22:0], bit_val};
          pixel_valid <= 1'b1;
          pixel_index <= pcnt;
          if (pcnt != 16'hFFFF) pcnt <= pcnt + 16'd1;
          shreg       <= '0;
          bitcnt      <= '0;
        end else begin
          shreg  <= {shreg[22:0], bit_val};
          bitcnt <= bitcnt + 5'd1;
        end
      end

      // Over-long high pulse: drop the partial pixel but keep the frame going.
      if (do_err) begin
        shreg     <= '0;
        bitcnt    <= '0;
        bit_error <= 1'b1;
      end

      // End of frame; a leftover partial pixel is reported and discarded.
      if (do_end) begin
        frame_done   <= busy;
        frame_pixels <= pcnt;
        bit_error    <= (bitcnt != 5'd0);
        pcnt         <= '0;
        shreg        <= '0;
        bitcnt       <= '0;
        busy         <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ws2812_receiver.sv
// Scoreboard bench for ws2812_receiver with shortened pulse timings.
// Expected pixels/frames are queued before stimulus and popped on DUT strobes.
// Stray strobes, data/index/count mismatches and leftover expectations are reported.
module tb_ws2812_receiver;
  localparam int TH = 3;
  localparam int MH = 12;
  localparam int RC = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        din;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [15:0] pixel_index;
  logic        frame_done;
  logic [15:0] frame_pixels;
  logic        bit_error;
  logic        busy;

  typedef struct packed {logic [23:0] d; logic [15:0] idx;} pix_t;
  typedef struct packed {logic [15:0] n; logic err;} frm_t;

  pix_t pq[$];
  frm_t fq[$];
  pix_t pe;
  frm_t fe;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   err_seen = 0;
  int   exp_err  = 0;

  ws2812_receiver #(.BIT_THRESHOLD(TH), .MAX_HIGH(MH), .RESET_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .din(din),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_index(pixel_index),
    .frame_done(frame_done), .frame_pixels(frame_pixels),
    .bit_error(bit_error), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int h, input int l);
    din = 1'b1;
    cyc(h);
    din = 1'b0;
    cyc(l);
  endtask

  task automatic send_bit(input logic b);
    if (b) pulse(4, 2);
    else   pulse(2, 4);
  endtask

  task automatic send_pixel(input logic [23:0] p, input logic [15:0] idx);
    pq.push_back({p, idx});
    for (int i = 23; i >= 0; i--) send_bit(p[i]);
  endtask

  task automatic end_frame(input logic [15:0] n, input logic err);
    fq.push_back({n, err});
    cyc(RC + 10);
  endtask

  // Strobe monitor: pops the scoreboard on every pixel/frame strobe.
  always @(negedge clk) begin
    if (!rst) begin
      if (pixel_valid && frame_done) chk("strobe_overlap", 40'd1, 40'd0);
      if (pixel_valid) begin
        if (pq.size() == 0) chk("pix_unexpected", 40'd1, 40'd0);
        else begin
          pe = pq.pop_front();
          chk("pix_data", {16'd0, pixel_data}, {16'd0, pe.d});
          chk("pix_index", {24'd0, pixel_index}, {24'd0, pe.idx});
        end
      end
      if (frame_done) begin
        if (fq.size() == 0) chk("frame_unexpected", 40'd1, 40'd0);
        else begin
          fe = fq.pop_front();
          chk("frame_pixels", {24'd0, frame_pixels}, {24'd0, fe.n});
          chk("frame_err", {39'd0, bit_error}, {39'd0, fe.err});
        end
      end else if (bit_error) begin
        err_seen++;
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] v;
    rst = 1'b1;
    din = 1'b0;
    cyc(3);
    chk("rst_data", {16'd0, pixel_data}, 40'd0);
    chk("rst_index", {24'd0, pixel_index}, 40'd0);
    chk("rst_frame_pixels", {24'd0, frame_pixels}, 40'd0);
    chk("rst_strobes", {37'd0, pixel_valid, frame_done, bit_error}, 40'd0);
    chk("rst_busy", {39'd0, busy}, 40'd0);
    rst = 1'b0;
    cyc(5);

    // Single pixel, then the line idles past the frame gap.
    send_pixel(24'h00FF00, 16'd0);
    chk("busy_mid", {39'd0, busy}, 40'd1);
    end_frame(16'd1, 1'b0);
    cyc(RC + 20);
    chk("hold_data", {16'd0, pixel_data}, {16'd0, 24'h00FF00});
    chk("busy_idle", {39'd0, busy}, 40'd0);

    // Decode threshold: TH-1 cycles high is a 0, TH cycles high is a 1.
    pq.push_back({24'h000001, 16'd0});
    for (int i = 0; i < 22; i++) send_bit(1'b0);
    pulse(TH - 1, 4);
    pulse(TH, 4);
    pq.push_back({24'hFFFFFE, 16'd1});
    for (int i = 0; i < 22; i++) send_bit(1'b1);
    pulse(TH, 4);
    pulse(TH - 1, 4);
    end_frame(16'd2, 1'b0);

    // One pixel plus a partial pixel at frame end.
    send_pixel(24'h123456, 16'd0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    end_frame(16'd1, 1'b1);

    // Over-long high pulse discards the partial pixel; frame carries on.
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    exp_err++;
    pulse(MH + 6, 2);
    send_pixel(24'hA5A5A5, 16'd0);
    end_frame(16'd1, 1'b0);
    chk("long_high_errors", err_seen, exp_err);

    // Long frame crossing 256 pixels.
    for (int i = 0; i < 400; i++) begin
      v = 16'(i);
      send_pixel({v[7:0], ~v[7:0], 8'hA5}, v);
    end
    end_frame(16'd400, 1'b0);
    chk("long_frame_drained", pq.size(), 0);

    // Reset in the middle of pixel 3.
    for (int i = 0; i < 3; i++) send_pixel({8'h3C, 8'(i), 8'hC3}, 16'(i));
    for (int i = 0; i < 12; i++) send_bit(i[0]);
    chk("busy_pre_rst", {39'd0, busy}, 40'd1);
    rst = 1'b1;
    din = 1'b0;
    #1;
    chk("mid_rst_data", {16'd0, pixel_data}, 40'd0);
    chk("mid_rst_index", {24'd0, pixel_index}, 40'd0);
    chk("mid_rst_frame_pixels", {24'd0, frame_pixels}, 40'd0);
    chk("mid_rst_strobes", {37'd0, pixel_valid, frame_done, bit_error}, 40'd0);
    chk("mid_rst_busy", {39'd0, busy}, 40'd0);
    cyc(3);
    rst = 1'b0;
    cyc(5);
    send_pixel(24'h0F0F0F, 16'd0);
    end_frame(16'd1, 1'b0);

    cyc(10);
    chk("pix_queue_empty", pq.size(), 0);
    chk("frame_queue_empty", fq.size(), 0);
    chk("error_count", err_seen, exp_err);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ws2812_receiver.md
WS2812_RECEIVER -- requirements
Module: ws2812_receiver

Interface
REQ-001 Parameter BIT_THRESHOLD, default 30: high-pulse length in clk cycles at or above which a bit decodes as 1 (50 MHz clk: T0H 20, T1H 40).
REQ-002 Parameter MAX_HIGH, default 100: high-pulse length in cycles that is a line error.
REQ-003 Parameter RESET_CYCLES, default 2500: low time in cycles that ends a frame (50 us at 50 MHz).
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 din  input  1  one-wire LED serial stream, asynchronous to clk.
REQ-007 pixel_data  output  24  last complete pixel, first received bit in bit 23 (GRB order as transmitted).
REQ-008 pixel_valid  output  1  one-cycle strobe, pixel_data/pixel_index valid.
REQ-009 pixel_index  output  16  0-based position of pixel in current frame.
REQ-010 frame_done  output  1  one-cycle strobe at frame end.
REQ-011 frame_pixels  output  16  complete pixels in the frame just ended, valid with frame_done.
REQ-012 bit_error  output  1  one-cycle strobe: partial pixel discarded or over-long high pulse.
REQ-013 busy  output  1  high from first decoded rising edge until frame end.

Function
REQ-014 din SHALL pass a 2-flop synchronizer plus a third flop for edge detection; all decode SHALL use synchronized samples only.
REQ-015 States SHALL be IDLE, HIGH, LOW, ERR.
- IDLE: rising edge -> HIGH.
- HIGH: falling edge -> LOW with bit decode; high count reaches MAX_HIGH -> ERR.
- LOW: rising edge -> HIGH; low count reaches RESET_CYCLES -> IDLE with frame end.
- ERR: falling edge -> LOW, no bit decoded.
REQ-016 High counter SHALL clear on each rising edge, count every cycle in HIGH and saturate; low counter likewise for LOW and ERR.
REQ-017 At a falling edge, bit = 1 iff high count >= BIT_THRESHOLD; bit SHALL shift into a 24-bit register MSB-first; a 5-bit bit counter SHALL increment.
REQ-018 On the 24th bit, pixel_data SHALL load the assembled word, pixel_valid SHALL pulse once, pixel_index SHALL equal the frame pixel count before increment, bit counter SHALL clear.
REQ-019 Output strobes SHALL be registered: pixel_valid is high in the cycle after the 3rd rising clk edge at which din of the 24th bit is sampled low.
REQ-020 Pixel count SHALL saturate at 16'hFFFF; further pixels still strobe with pixel_index 16'hFFFF.
REQ-021 Frame end SHALL pulse frame_done with frame_pixels = pixel count, clear pixel and bit counters, drop busy next cycle; frame_done SHALL NOT fire if no rising edge occurred since the previous frame end.
REQ-022 Frame end with bit counter nonzero SHALL also pulse bit_error in the same cycle and discard the partial bits.
REQ-023 High count reaching MAX_HIGH SHALL pulse bit_error once, discard partial bits, keep pixel count; frame continues.
REQ-024 pixel_valid and frame_done SHALL never be high in the same cycle.
REQ-025 pixel_data SHALL hold its value between strobes.

Reset
REQ-026 rst high SHALL immediately force IDLE, clear all counters, shift register and synchronizer flops to 0; pixel_data 0, pixel_index 0, frame_pixels 0, all strobes 0, busy 0.
REQ-027 Reset mid-frame SHALL discard the frame with no frame_done or bit_error; after release, line low then high SHALL start a new frame at pixel_index 0.

Verification
REQ-028 Single pixel 24'h00FF00 (T0H 20, T1H 40, 62-cycle bit period), then 2500 low -> one pixel_valid, data 24'h00FF00, index 0; frame_done with frame_pixels 1.
REQ-029 400 pixels, pixel i = {i[7:0], ~i[7:0], 8'hA5} -> 400 strobes, indices 0..399 in order, matching data; frame_done frame_pixels 400.
REQ-030 High pulses of 29 and 30 cycles -> decode 0 and 1 respectively.
REQ-031 Frame of 1 pixel plus 5 bits, then reset gap -> one pixel_valid; frame_done frame_pixels 1 with bit_error same cycle.
REQ-032 High pulse of 150 cycles mid-pixel -> one bit_error at high count 100, no pixel_valid; following 24 good bits -> pixel_valid index 0.
REQ-033 rst asserted after 12 bits of pixel 3 -> outputs 0 same cycle; no frame_done; next frame starts at index 0.
